route_read_ctrl: RTL and testbench

ROUTE_READ_CTRL -- requirements
Module: route_read_ctrl

---
 rtl/route_read_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_route_read_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_read_ctrl.sv
// route_read_ctrl: reads bursts of words out of a route FIFO and streams them
// downstream through a 2-entry skid buffer.
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse launching a job (burst_len x burst_num words)
//   burst_len     words per burst, sampled on start
//   burst_num     bursts per job, sampled on start
//   M_count       registered burst length for the FIFO ready comparator
//   M_Ready       FIFO holds at least M_count words (one-cycle lag)
//   rd_en         FIFO read strobe; data returns on fifo_dout next cycle
//   fifo_dout     FIFO read data
//   m_valid/m_data/m_ready  downstream stream
//   busy          job in progress
//   done          one-cycle pulse, one cycle after the final word is accepted
module route_read_ctrl #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   burst_len,
    input  logic [15:0]          burst_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = ADDR_BITS + 1;
    localparam int unsigned NUM_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BURST,
        GAP,
        FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   mcount_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   burst_q, burst_d;
    logic [NUM_W-1:0]   burst_inc;
    logic               gap_q, gap_d;
    logic               done_d;

    // Output buffer: 2 entries, FIFO ordered
    logic [WIDTH-1:0]   buf_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q;
    logic               push, pop;
    logic [2:0]         pending;
    logic               space_ok;

    // A read issued last cycle lands in the buffer this cycle
    assign push      = inflight_q;
    assign pop       = m_valid & m_ready;
    assign occ_d     = 2'(occ_q + 2'(push) - 2'(pop));
    // Words buffered or in flight after this cycle's pop must leave room for one more
    assign pending   = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign space_ok  = (pending < 3'd2);
    assign burst_inc = burst_q + NUM_W'(1);

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];
    assign busy    = (state_q != IDLE);

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        num_d    = num_q;
        word_d   = word_q;
        burst_d  = burst_q;
        gap_d    = gap_q;
        mcount_d = M_count;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((burst_len != '0) && (burst_num != '0)) begin
                        len_d    = burst_len;
                        num_d    = burst_num;
                        mcount_d = burst_len;
                        word_d   = '0;
                        burst_d  = '0;
                        state_d  = WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (M_Ready) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (space_ok) begin
                    rd_en = 1'b1;
                    if (word_q == len_q - CNT_W'(1)) begin
                        word_d  = '0;
                        burst_d = burst_inc;
                        gap_d   = 1'b0;
                        state_d = (burst_inc < num_q) ? GAP : FLUSH;
                    end else begin
                        word_d = word_q + CNT_W'(1);
                    end
                end
            end
            // Two cycles so the FIFO's lagging M_Ready reflects the new level
            GAP: begin
                if (gap_q) begin
                    state_d = WAIT;
                end else begin
                    gap_d = 1'b1;
                end
            end
            // Finish once the final word leaves with nothing behind it
            FLUSH: begin
                if (occ_d == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and buffer bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            num_q      <= '0;
            word_q     <= '0;
            burst_q    <= '0;
            gap_q      <= 1'b0;
            M_count    <= '0;
            done       <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            num_q      <= num_d;
            word_q     <= word_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
            M_count    <= mcount_d;
            done       <= done_d;
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Buffer storage; validity is tracked by occ_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_route_read_ctrl.sv
// Testbench for route_read_ctrl: table of jobs, hand-written corner sequences
// and randomized jobs, all checked against a word-level reference model.
module tb_route_read_ctrl;

    localparam int unsigned WIDTH     = 128;
    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned CW        = ADDR_BITS + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CW-1:0]     burst_len;
    logic [15:0]       burst_num;
    logic [CW-1:0]     M_count;
    logic              M_Ready;
    logic              rd_en;
    logic [WIDTH-1:0]  fifo_dout;
    logic              m_valid;
    logic [WIDTH-1:0]  m_data;
    logic              m_ready;
    logic              busy;
    logic              done;

    route_read_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .burst_num(burst_num), .M_count(M_count), .M_Ready(M_Ready),
        .rd_en(rd_en), .fifo_dout(fifo_dout), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: every read issued returns one word, delivered in order
    logic [WIDTH-1:0] exp_q[$];
    int               iss_q[$];
    int               rd_cyc_q[$];
    bit               job_active = 1'b0;
    int               job_total  = 0;
    int               job_issued = 0;
    int               job_popped = 0;
    bit               exp_done   = 1'b0;
    bit               pend_rd    = 1'b0;
    logic [WIDTH-1:0] pend_word  = '0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    int               rd_count   = 0;
    int               done_count = 0;
    int               first_rd   = -1;
    int               last_rd    = -1;
    int               mode_m     = 0;
    int               mode_mm    = 0;

    typedef struct {
        int len;
        int num;
        int mrdy_rand;
        int Mrdy_rand;
        int exp_reads;
        int exp_dones;
        int exp_span;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_data(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: check outputs against the model, advance model, drive FIFO data
    task automatic tick();
        bit               pop;
        bit               idle;
        bit               vexp;
        logic [WIDTH-1:0] w;
        #1;
        pop  = m_valid && m_ready;
        idle = !job_active;
        w    = WIDTH'({$urandom(), $urandom(), $urandom(), $urandom()});
        if (!rst) begin
            chk("done", done, exp_done);
            chk("busy", busy, job_active);
            vexp = (exp_q.size() > 0) && (iss_q[0] <= cyc - 2);
            chk("m_valid", m_valid, vexp);
            if (m_valid && vexp) chk_data("m_data", m_data, exp_q[0]);
            if (prev_stall) chk_data("m_data_hold", m_data, prev_data);
            if (rd_en) begin
                chk("rd_en_room", ((job_issued - job_popped - (pop ? 1 : 0)) < 2), 1);
                chk("rd_en_in_job", (job_active && (job_issued < job_total)), 1);
            end
        end
        if (done) done_count++;
        exp_done = 1'b0;
        pend_rd  = rd_en;
        pend_word = w;
        if (rst) begin
            exp_q.delete();
            iss_q.delete();
            job_active = 1'b0;
            job_issued = 0;
            job_popped = 0;
            prev_stall = 1'b0;
        end else begin
            if (pop && (exp_q.size() > 0)) begin
                void'(exp_q.pop_front());
                void'(iss_q.pop_front());
                job_popped++;
                if (job_active && (job_popped == job_total)) begin
                    job_active = 1'b0;
                    exp_done   = 1'b1;
                end
            end
            if (rd_en) begin
                exp_q.push_back(w);
                iss_q.push_back(cyc);
                rd_cyc_q.push_back(cyc);
                job_issued++;
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (start && idle) begin
                if ((burst_len != '0) && (burst_num != '0)) begin
                    job_active = 1'b1;
                    job_total  = int'(burst_len) * int'(burst_num);
                    job_issued = 0;
                    job_popped = 0;
                end else begin
                    exp_done = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        fifo_dout = pend_rd ? pend_word : WIDTH'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic drive();
        m_ready = (mode_m != 0)  ? 1'($urandom_range(0, 1)) : 1'b1;
        M_Ready = (mode_mm != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic clear_stats();
        rd_count   = 0;
        done_count = 0;
        first_rd   = -1;
        last_rd    = -1;
        rd_cyc_q.delete();
    endtask

    task automatic run_job(input int len, input int num, input int mr, input int mmr,
                           output int reads, output int dones, output int span);
        clear_stats();
        mode_m    = mr;
        mode_mm   = mmr;
        burst_len = CW'(len);
        burst_num = 16'(num);
        start     = 1'b1;
        drive();
        tick();
        start = 1'b0;
        for (int i = 0; (i < 3000) && (done_count == 0); i++) begin
            drive();
            tick();
        end
        if (done_count == 0) chk("job_timeout", 0, 1);
        repeat (3) begin
            drive();
            tick();
        end
        reads = rd_count;
        dones = done_count;
        span  = last_rd - first_rd;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; (i < 500) && (done_count == 0); i++) tick();
        if (done_count == 0) chk(name, 0, 1);
        repeat (2) tick();
    endtask

    vec_t vecs[6];

    initial begin
        int reads, dones, span, r0, rcyc;

        vecs[0] = '{4, 1, 0, 0,  4, 1,  3};
        vecs[1] = '{3, 2, 1, 1,  6, 1, -1};
        vecs[2] = '{0, 5, 0, 0,  0, 1, -1};
        vecs[3] = '{5, 0, 0, 0,  0, 1, -1};
        vecs[4] = '{1, 4, 1, 0,  4, 1, -1};
        vecs[5] = '{7, 3, 0, 1, 21, 1, -1};

        rst = 1'b1; start = 1'b0; burst_len = '0; burst_num = '0;
        M_Ready = 1'b0; m_ready = 1'b0; fifo_dout = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_M_count", M_count, 0);

        // Table of jobs
        foreach (vecs[k]) begin
            run_job(vecs[k].len, vecs[k].num, vecs[k].mrdy_rand, vecs[k].Mrdy_rand, reads, dones, span);
            chk($sformatf("vec%0d_reads", k), reads, vecs[k].exp_reads);
            chk($sformatf("vec%0d_dones", k), dones, vecs[k].exp_dones);
            if (vecs[k].exp_span >= 0) chk($sformatf("vec%0d_span", k), span, vecs[k].exp_span);
        end

        // Gap of exactly 2 cycles with M_Ready held high
        run_job(3, 2, 0, 0, reads, dones, span);
        chk("gap_reads", reads, 6);
        chk("gap_spacing", rd_cyc_q[3] - rd_cyc_q[2], 4);
        chk("gap_M_count", M_count, 3);

        // M_Ready dropped during GAP: second burst held in WAIT
        clear_stats();
        M_Ready = 1'b1; m_ready = 1'b1;
        burst_len = CW'(3); burst_num = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; (i < 50) && (rd_count < 3); i++) tick();
        M_Ready = 1'b0;
        repeat (10) tick();
        chk("wait_hold_reads", rd_count, 3);
        M_Ready = 1'b1;
        rcyc = cyc;
        tick();
        for (int i = 0; (i < 50) && (rd_count < 6); i++) tick();
        chk("wait_release", rd_cyc_q[3] - rcyc, 1);
        wait_done("wait_timeout");
        chk("wait_words", rd_count, 6);
        chk("wait_dones", done_count, 1);

        // Downstream stall for 10 cycles mid-burst
        clear_stats();
        M_Ready = 1'b1; m_ready = 1'b1;
        burst_len = CW'(8); burst_num = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        m_ready = 1'b0;
        repeat (4) tick();
        r0 = rd_count;
        repeat (6) tick();
        chk("stall_no_rd", rd_count - r0, 0);
        chk("stall_buffered", job_issued - job_popped, 2);
        chk("stall_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_done("stall_timeout");
        chk("stall_reads", rd_count, 8);
        chk("stall_dones", done_count, 1);

        // Reset mid-burst with 2 words buffered and a read issued in the reset cycle
        clear_stats();
        M_Ready = 1'b1; m_ready = 1'b0;
        burst_len = CW'(8); burst_num = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_valid", m_valid, 1);
        m_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        chk("rst_no_late_word", m_valid, 0);
        run_job(4, 1, 0, 0, reads, dones, span);
        chk("post_rst_reads", reads, 4);
        chk("post_rst_dones", dones, 1);

        // start re-pulsed while busy is ignored
        clear_stats();
        M_Ready = 1'b1; m_ready = 1'b1;
        burst_len = CW'(5); burst_num = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        burst_len = CW'(1); burst_num = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_M_count", M_count, 5);
        wait_done("restart_timeout");
        chk("restart_reads", rd_count, 10);
        chk("restart_dones", done_count, 1);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int l, n;
            l = int'($urandom_range(1, 6));
            n = int'($urandom_range(1, 3));
            run_job(l, n, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), reads, dones, span);
            chk($sformatf("rand%0d_reads", j), reads, l * n);
            chk($sformatf("rand%0d_dones", j), dones, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
